// File: rtl/seg_scan_decoder.sv
// Readback monitor for the multiplexed 7-segment score display: synchronizes seg/an,
// debounces each scan position, decodes glyphs and assembles left-to-right frames.
module seg_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [13:0] score,
  output logic        score_valid,
  output logic        glyph_err,
  output logic        frame_err
);

  localparam logic [7:0] LP_SETTLE = 8'(SETTLE);
  localparam logic [1:0] POS_L  = 2'd0;
  localparam logic [1:0] POS_ML = 2'd1;
  localparam logic [1:0] POS_MR = 2'd2;
  localparam logic [1:0] POS_R  = 2'd3;

  typedef enum logic [1:0] {WAIT_L, GOT_L, GOT_ML, GOT_MR} state_t;

  // Glyphs are active-low, bit order {a,b,c,d,e,f,g}.
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'b0000001: f_decode = 5'h10;
      7'b1001111: f_decode = 5'h11;
      7'b0010010: f_decode = 5'h12;
      7'b0000110: f_decode = 5'h13;
      7'b1001100: f_decode = 5'h14;
      7'b0100100: f_decode = 5'h15;
      7'b0100000: f_decode = 5'h16;
      7'b0001111: f_decode = 5'h17;
      7'b0000000: f_decode = 5'h18;
      7'b0000100: f_decode = 5'h19;
      default:    f_decode = 5'h00;
    endcase
  endfunction

  function automatic logic [13:0] f_score(input logic [3:0] l, input logic [3:0] ml,
                                          input logic [3:0] mr, input logic [3:0] r);
    logic [13:0] v_l, v_ml, v_mr, v_r;
    v_l  = {10'd0, l};
    v_ml = {10'd0, ml};
    v_mr = {10'd0, mr};
    v_r  = {10'd0, r};
    f_score = v_l * 14'd1000 + v_ml * 14'd100 + v_mr * 14'd10 + v_r;
  endfunction

  logic [3:0]  r_an_p0, r_an_p1;
  logic [6:0]  r_seg_p0, r_seg_p1;
  logic [10:0] r_prev;
  logic [7:0]  r_cnt;
  logic        r_taken;
  logic [10:0] w_smp_p0, w_smp_p1;
  logic        w_diff, w_accept;

  assign w_smp_p0 = {r_an_p0, r_seg_p0};
  assign w_smp_p1 = {r_an_p1, r_seg_p1};
  assign w_diff   = (w_smp_p1 != r_prev);
  // The sample still in the first sync stage must agree too, so a position
  // has to dwell SETTLE+2 cycles at the pins before it is taken.
  assign w_accept = (r_cnt == LP_SETTLE) && !r_taken && !w_diff && (w_smp_p0 == r_prev);

  // Stage p0/p1: synchronizer, then stability counter on the p1 sample
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_an_p0  <= 4'hF;
      r_an_p1  <= 4'hF;
      r_seg_p0 <= 7'h7F;
      r_seg_p1 <= 7'h7F;
      r_prev   <= 11'h7FF;
      r_cnt    <= 8'd0;
      r_taken  <= 1'b0;
    end else begin
      r_an_p0  <= an;
      r_an_p1  <= r_an_p0;
      r_seg_p0 <= seg;
      r_seg_p1 <= r_seg_p0;
      r_prev   <= w_smp_p1;
      if (w_diff) begin
        r_cnt   <= 8'd1;
        r_taken <= 1'b0;
      end else begin
        if (r_cnt != LP_SETTLE) r_cnt <= r_cnt + 8'd1;
        if (w_accept) r_taken <= 1'b1;
      end
    end
  end

  logic [4:0]  w_dec;
  logic [3:0]  w_digit;
  logic        w_glyph_ok, w_an_ok;
  logic [1:0]  w_pos;

  assign w_dec      = f_decode(r_prev[6:0]);
  assign w_glyph_ok = w_dec[4];
  assign w_digit    = w_dec[3:0];

  always_comb begin
    w_an_ok = 1'b1;
    w_pos   = POS_L;
    case (r_prev[10:7])
      4'b0111: w_pos = POS_L;
      4'b1011: w_pos = POS_ML;
      4'b1101: w_pos = POS_MR;
      4'b1110: w_pos = POS_R;
      default: w_an_ok = 1'b0;
    endcase
  end

  state_t      r_state, w_state_nxt;
  logic        w_glyph_err, w_frame_err, w_complete;
  logic        w_store_l, w_store_ml, w_store_mr, w_ooo;
  logic [3:0]  r_hold_l, r_hold_ml, r_hold_mr;
  logic [15:0] r_digits;
  logic [13:0] r_score;
  logic        r_score_valid, r_glyph_err, r_frame_err;

  always_comb begin
    w_state_nxt = r_state;
    w_glyph_err = 1'b0;
    w_frame_err = 1'b0;
    w_complete  = 1'b0;
    w_store_l   = 1'b0;
    w_store_ml  = 1'b0;
    w_store_mr  = 1'b0;
    w_ooo       = 1'b0;
    if (w_accept && w_an_ok) begin
      if (!w_glyph_ok) begin
        w_glyph_err = 1'b1;
        w_state_nxt = WAIT_L;
      end else begin
        case (r_state)
          WAIT_L: if (w_pos == POS_L) begin
            w_store_l   = 1'b1;
            w_state_nxt = GOT_L;
          end
          GOT_L: if (w_pos == POS_ML) begin
            w_store_ml  = 1'b1;
            w_state_nxt = GOT_ML;
          end else w_ooo = 1'b1;
          GOT_ML: if (w_pos == POS_MR) begin
            w_store_mr  = 1'b1;
            w_state_nxt = GOT_MR;
          end else w_ooo = 1'b1;
          default: if (w_pos == POS_R) begin
            w_complete  = 1'b1;
            w_state_nxt = WAIT_L;
          end else w_ooo = 1'b1;
        endcase
        if (w_ooo) begin
          w_frame_err = 1'b1;
          w_store_l   = (w_pos == POS_L);
          w_state_nxt = (w_pos == POS_L) ? GOT_L : WAIT_L;
        end
      end
    end
  end

  // Stage p2: frame state, holding registers and registered results
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state       <= WAIT_L;
      r_hold_l      <= 4'd0;
      r_hold_ml     <= 4'd0;
      r_hold_mr     <= 4'd0;
      r_digits      <= 16'd0;
      r_score       <= 14'd0;
      r_score_valid <= 1'b0;
      r_glyph_err   <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_score_valid <= w_complete;
      r_glyph_err   <= w_glyph_err;
      r_frame_err   <= w_frame_err;
      if (w_store_l)  r_hold_l  <= w_digit;
      if (w_store_ml) r_hold_ml <= w_digit;
      if (w_store_mr) r_hold_mr <= w_digit;
      if (w_complete) begin
        r_digits <= {r_hold_l, r_hold_ml, r_hold_mr, w_digit};
        r_score  <= f_score(r_hold_l, r_hold_ml, r_hold_mr, w_digit);
      end
    end
  end

  assign digits      = r_digits;
  assign score       = r_score;
  assign score_valid = r_score_valid;
  assign glyph_err   = r_glyph_err;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives display scans at 1/16 of clk and
// checks decoded frames, error pulses, latency and dwell boundaries.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [13:0] score;
  logic        score_valid, glyph_err, frame_err;

  seg_scan_decoder #(.SETTLE(4)) dut (
    .clk(clk), .clr_n(clr_n), .seg(seg), .an(an),
    .digits(digits), .score(score), .score_valid(score_valid),
    .glyph_err(glyph_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int sv_n = 0, ge_n = 0, fe_n = 0, sv_cyc = 0;
  int n_chk = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (score_valid) begin
      sv_n   <= sv_n + 1;
      sv_cyc <= cyc;
    end
    if (glyph_err) ge_n <= ge_n + 1;
    if (frame_err) fe_n <= fe_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [6:0] g(input int d);
    case (d)
      0: g = 7'b0000001;
      1: g = 7'b1001111;
      2: g = 7'b0010010;
      3: g = 7'b0000110;
      4: g = 7'b1001100;
      5: g = 7'b0100100;
      6: g = 7'b0100000;
      7: g = 7'b0001111;
      8: g = 7'b0000000;
      default: g = 7'b0000100;
    endcase
  endfunction

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int l, input int ml, input int mr, input int r);
    show(4'b0111, g(l), 16);
    show(4'b1011, g(ml), 16);
    show(4'b1101, g(mr), 16);
    show(4'b1110, g(r), 16);
  endtask

  int sv0, ge0, fe0, c0;

  initial begin
    clr_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_score", 32'(score), 0);
    chk("rst_pulses", {29'd0, score_valid, glyph_err, frame_err}, 0);
    clr_n = 1'b1;
    show(4'hF, 7'h7F, 8);

    // frame 0427, then reset in the middle of the next scan
    frame(0, 4, 2, 7);
    chk("pre_rst_score", 32'(score), 427);
    sv0 = sv_n; ge0 = ge_n; fe0 = fe_n;
    show(4'b0111, g(0), 16);
    show(4'b1011, g(4), 8);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    chk("midrst_digits", 32'(digits), 0);
    chk("midrst_score", 32'(score), 0);
    show(4'b1011, g(4), 8);
    show(4'b1101, g(2), 16);
    show(4'b1110, g(7), 16);
    chk("midrst_no_frame", 32'(sv_n - sv0), 0);
    frame(0, 4, 2, 7);
    chk("post_rst_score", 32'(score), 427);
    chk("post_rst_digits", 32'(digits), 32'h0427);
    chk("post_rst_errs", 32'((ge_n - ge0) + (fe_n - fe0)), 0);

    // 1023 twice back-to-back, latency from right-digit pin change
    sv0 = sv_n;
    show(4'b0111, g(1), 16);
    show(4'b1011, g(0), 16);
    show(4'b1101, g(2), 16);
    an = 4'b1110; seg = g(3); c0 = cyc;
    repeat (16) @(negedge clk);
    chk("latency", 32'(sv_cyc - c0), 7);
    frame(1, 0, 2, 3);
    show(4'hF, 7'h7F, 16);
    chk("norm_count", 32'(sv_n - sv0), 2);
    chk("norm_score", 32'(score), 1023);
    chk("norm_digits", 32'(digits), 32'h1023);

    // start-up alignment: begin at midright
    sv0 = sv_n; ge0 = ge_n; fe0 = fe_n;
    show(4'b1101, g(5), 16);
    show(4'b1110, g(6), 16);
    chk("align_quiet", 32'((sv_n - sv0) + (ge_n - ge0) + (fe_n - fe0)), 0);
    frame(8, 7, 6, 5);
    chk("align_score", 32'(score), 8765);
    chk("align_count", 32'(sv_n - sv0), 1);

    // out-of-order left resyncs
    sv0 = sv_n; fe0 = fe_n;
    show(4'b0111, g(5), 16);
    show(4'b1011, g(1), 16);
    show(4'b0111, g(9), 16);
    chk("ooo_ferr", 32'(fe_n - fe0), 1);
    show(4'b1011, g(0), 16);
    show(4'b1101, g(0), 16);
    show(4'b1110, g(0), 16);
    chk("ooo_score", 32'(score), 9000);
    chk("ooo_digits", 32'(digits), 32'h9000);
    chk("ooo_count", 32'(sv_n - sv0), 1);

    // blank midleft glyph
    sv0 = sv_n; ge0 = ge_n; fe0 = fe_n;
    show(4'b0111, g(2), 16);
    show(4'b1011, 7'h7F, 16);
    chk("bad_gerr", 32'(ge_n - ge0), 1);
    chk("bad_score_held", 32'(score), 9000);
    frame(4, 3, 2, 1);
    chk("bad_recover", 32'(score), 4321);
    chk("bad_no_ferr", 32'(fe_n - fe0), 0);

    // illegal glyph in an out-of-order position: glyph_err only
    ge0 = ge_n; fe0 = fe_n;
    show(4'b0111, g(1), 16);
    show(4'b1101, 7'h55, 16);
    chk("prio_gerr", 32'(ge_n - ge0), 1);
    chk("prio_ferr", 32'(fe_n - fe0), 0);

    // an=0000 in place of midleft
    sv0 = sv_n;
    show(4'b0111, g(3), 16);
    show(4'b0000, g(4), 16);
    show(4'b1101, g(5), 16);
    show(4'b1110, g(6), 16);
    chk("an0000_no_frame", 32'(sv_n - sv0), 0);

    // midleft held SETTLE+1 cycles: missed
    sv0 = sv_n; fe0 = fe_n;
    show(4'b0111, g(3), 16);
    show(4'b1011, g(4), 5);
    show(4'b1101, g(5), 16);
    show(4'b1110, g(6), 16);
    chk("short_no_frame", 32'(sv_n - sv0), 0);
    chk("short_ferr", 32'(fe_n - fe0), 1);
    chk("short_score_held", 32'(score), 4321);

    // midleft held SETTLE+2 cycles: accepted
    sv0 = sv_n;
    show(4'b0111, g(3), 16);
    show(4'b1011, g(4), 6);
    show(4'b1101, g(5), 16);
    show(4'b1110, g(6), 16);
    chk("dwell_min_count", 32'(sv_n - sv0), 1);
    chk("dwell_min_score", 32'(score), 3456);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
